// File: rtl/cv32e40p_apu_wb_buffer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cv32e40p_apu_wb_buffer: pairs FPU results with issue-time destination     |
// | tags, buffers them for the RF write port, accumulates fflags.           |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module cv32e40p_apu_wb_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_waddr_i,
  output logic              issue_ready_o,
  input  logic              apu_rvalid_i,
  input  logic [31:0]       apu_rdata_i,
  input  logic [4:0]        apu_rflags_i,
  output logic              wb_valid_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [31:0]       wb_wdata_o,
  input  logic              wb_ready_i,
  output logic [4:0]        fflags_o,
  input  logic              fflags_clr_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RES_W = ADDR_W + 32 + 5;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] tag_mem_q [DEPTH];
  logic [RES_W-1:0]  res_mem_q [DEPTH];

  logic [PTR_W-1:0] tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
  logic [PTR_W-1:0] res_wptr_q, res_wptr_d, res_rptr_q, res_rptr_d;
  logic [CNT_W-1:0] tag_cnt_q, tag_cnt_d, res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic              issue_ok, tag_avail, bypass, result_ok;
  logic              tag_push, tag_pop, wb_hs;
  logic [ADDR_W-1:0] res_tag;
  logic [RES_W-1:0]  res_head;

  always_comb begin
    issue_ok  = issue_valid_i && (cnt_q != DEPTH_C);
    tag_avail = (tag_cnt_q != '0);
    // Zero-latency FPU: result arrives with its own issue, tag FIFO skipped.
    bypass    = issue_ok && apu_rvalid_i && !tag_avail;
    result_ok = apu_rvalid_i && (tag_avail || bypass);
    tag_push  = issue_ok && !bypass;
    tag_pop   = result_ok && !bypass;
    res_tag   = bypass ? issue_waddr_i : tag_mem_q[tag_rptr_q];
    res_head  = res_mem_q[res_rptr_q];
    wb_hs     = (res_cnt_q != '0) && wb_ready_i;

    tag_wptr_d = tag_push ? tag_wptr_q + PTR_W'(1) : tag_wptr_q;
    tag_rptr_d = tag_pop  ? tag_rptr_q + PTR_W'(1) : tag_rptr_q;
    tag_cnt_d  = tag_cnt_q + CNT_W'(tag_push) - CNT_W'(tag_pop);

    res_wptr_d = result_ok ? res_wptr_q + PTR_W'(1) : res_wptr_q;
    res_rptr_d = wb_hs     ? res_rptr_q + PTR_W'(1) : res_rptr_q;
    res_cnt_d  = res_cnt_q + CNT_W'(result_ok) - CNT_W'(wb_hs);

    cnt_d    = cnt_q + CNT_W'(issue_ok) - CNT_W'(wb_hs);
    busy_d   = (cnt_d != '0);
    fflags_d = (fflags_clr_i ? 5'd0 : fflags_q) | (wb_hs ? res_head[4:0] : 5'd0);
    err_d    = err_q | (issue_valid_i && !issue_ok) | (apu_rvalid_i && !result_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
      tag_cnt_q  <= '0;
      res_wptr_q <= '0;
      res_rptr_q <= '0;
      res_cnt_q  <= '0;
      cnt_q      <= '0;
      fflags_q   <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tag_wptr_q <= tag_wptr_d;
      tag_rptr_q <= tag_rptr_d;
      tag_cnt_q  <= tag_cnt_d;
      res_wptr_q <= res_wptr_d;
      res_rptr_q <= res_rptr_d;
      res_cnt_q  <= res_cnt_d;
      cnt_q      <= cnt_d;
      fflags_q   <= fflags_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: occupancy counters qualify every read.
  always_ff @(posedge clk_i) begin
    if (tag_push) tag_mem_q[tag_wptr_q] <= issue_waddr_i;
    if (result_ok) res_mem_q[res_wptr_q] <= {res_tag, apu_rdata_i, apu_rflags_i};
  end

  assign issue_ready_o = (cnt_q != DEPTH_C);
  assign wb_valid_o    = (res_cnt_q != '0);
  assign wb_waddr_o    = wb_valid_o ? res_head[RES_W-1 -: ADDR_W] : '0;
  assign wb_wdata_o    = wb_valid_o ? res_head[36:5] : 32'd0;
  assign fflags_o      = fflags_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_apu_wb_buffer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_cv32e40p_apu_wb_buffer: table vectors plus scoreboard bench.          |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_cv32e40p_apu_wb_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_waddr;
  logic              issue_ready;
  logic              apu_rvalid;
  logic [31:0]       apu_rdata;
  logic [4:0]        apu_rflags;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_waddr;
  logic [31:0]       wb_wdata;
  logic              wb_ready;
  logic [4:0]        fflags;
  logic              fflags_clr;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  cv32e40p_apu_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_waddr_i(issue_waddr), .issue_ready_o(issue_ready),
    .apu_rvalid_i(apu_rvalid), .apu_rdata_i(apu_rdata), .apu_rflags_i(apu_rflags),
    .wb_valid_o(wb_valid), .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata), .wb_ready_i(wb_ready),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr), .busy_o(busy), .err_o(err)
  );

  typedef struct {
    logic              iv;
    logic [ADDR_W-1:0] wa;
    logic              rv;
    logic [31:0]       rd;
    logic [4:0]        rf;
    logic              wr;
    logic              clr;
    logic              ev;
    logic              er;
    logic              eb;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       data;
    logic [4:0]        flags;
  } res_t;

  logic [ADDR_W-1:0] tagq[$];
  res_t              resq[$];
  int                cnt_m;
  logic [4:0]        ff_m;
  logic              err_m;

  int n_total = 0;
  int n_pass  = 0;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic iv, input logic [ADDR_W-1:0] wa, input logic rv,
                              input logic [31:0] rd, input logic [4:0] rf,
                              input logic wr, input logic clr);
    vec_t v;
    v = '{iv, wa, rv, rd, rf, wr, clr, 1'b0, 1'b0, 1'b0};
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; issue_valid = 0; issue_waddr = '0; apu_rvalid = 0;
    apu_rdata = '0; apu_rflags = '0; wb_ready = 0; fflags_clr = 0;
    @(posedge clk); #1;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_waddr", wb_waddr, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    tagq.delete(); resq.delete(); cnt_m = 0; ff_m = '0; err_m = 0;
    rst_n = 1'b1;
  endtask

  // Drive one cycle, compare against the scoreboard before the edge, then advance the model.
  task automatic step(input vec_t v, input bit has_exp);
    bit   hs, iss_ok, byp;
    res_t r;
    issue_valid = v.iv; issue_waddr = v.wa; apu_rvalid = v.rv;
    apu_rdata = v.rd; apu_rflags = v.rf; wb_ready = v.wr; fflags_clr = v.clr;
    @(negedge clk);
    chk("wb_valid", wb_valid, (resq.size() != 0));
    chk("issue_ready", issue_ready, (cnt_m != DEPTH));
    chk("busy", busy, (cnt_m != 0));
    chk("err", err, err_m);
    chk("fflags", fflags, ff_m);
    if (resq.size() != 0) begin
      chk("wb_waddr", wb_waddr, resq[0].waddr);
      chk("wb_wdata", wb_wdata, resq[0].data);
    end
    if (has_exp) begin
      chk("vec_wb_valid", wb_valid, v.ev);
      chk("vec_issue_ready", issue_ready, v.er);
      chk("vec_busy", busy, v.eb);
    end
    hs = v.wr && (resq.size() != 0);
    ff_m = (v.clr ? 5'd0 : ff_m) | (hs ? resq[0].flags : 5'd0);
    if (hs) void'(resq.pop_front());
    iss_ok = v.iv && (cnt_m != DEPTH);
    if (v.iv && !iss_ok) err_m = 1;
    byp = 0;
    if (v.rv) begin
      if (tagq.size() != 0) begin
        r.waddr = tagq.pop_front(); r.data = v.rd; r.flags = v.rf; resq.push_back(r);
      end else if (iss_ok) begin
        byp = 1; r.waddr = v.wa; r.data = v.rd; r.flags = v.rf; resq.push_back(r);
      end else err_m = 1;
    end
    if (iss_ok && !byp) tagq.push_back(v.wa);
    cnt_m = cnt_m + int'(iss_ok) - int'(hs);
    @(posedge clk); #1;
    issue_valid = 0; apu_rvalid = 0; fflags_clr = 0;
  endtask

  initial begin
    //           iv wa     rv rd            rf     wr clr ev er eb
    vecs[0] = '{1, 6'd5, 0, 32'h0,        5'h00, 1, 0, 0, 1, 0};
    vecs[1] = '{0, 6'd0, 0, 32'h0,        5'h00, 1, 0, 0, 1, 1};
    vecs[2] = '{0, 6'd0, 1, 32'h3F800000, 5'h01, 1, 0, 0, 1, 1};
    vecs[3] = '{0, 6'd0, 0, 32'h0,        5'h00, 1, 0, 1, 1, 1};
    vecs[4] = '{0, 6'd0, 0, 32'h0,        5'h00, 1, 0, 0, 1, 0};
    vecs[5] = '{1, 6'd9, 1, 32'hDEADBEEF, 5'h00, 0, 0, 0, 1, 0};
    vecs[6] = '{0, 6'd0, 0, 32'h0,        5'h00, 1, 0, 1, 1, 1};
    vecs[7] = '{0, 6'd0, 0, 32'h0,        5'h00, 0, 0, 0, 1, 0};

    do_reset();
    for (int i = 0; i < 4; i++) step(vecs[i], 1);
    chk("single_fflags", fflags, 5'h01);
    step(vecs[4], 1);
    chk("single_busy", busy, 0);
    step(vecs[5], 1);
    chk("bypass_waddr", wb_waddr, 9);
    chk("bypass_wdata", wb_wdata, 32'hDEADBEEF);
    step(vecs[6], 1);
    step(vecs[7], 1);
    chk("bypass_err", err, 0);

    // Fill all credits, overflow issue, then drain in order.
    do_reset();
    for (int i = 1; i <= 4; i++) step(mk(1, ADDR_W'(i), 0, 0, 0, 0, 0), 0);
    chk("full_ready_low", issue_ready, 0);
    for (int i = 1; i <= 4; i++) step(mk(0, 0, 1, 32'h100 + i, 5'(i), 0, 0), 0);
    chk("full_head_waddr", wb_waddr, 1);
    step(mk(1, 6'd7, 0, 0, 0, 0, 0), 0);
    chk("overflow_err", err, 1);
    chk("overflow_ready", issue_ready, 0);
    step(mk(0, 0, 0, 0, 0, 1, 0), 0);
    chk("credit_back", issue_ready, 1);
    for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 0, 0, 1, 0), 0);
    chk("drain_fflags", fflags, 5'h07);

    // Handshake and issue in the same cycle at cnt=3.
    do_reset();
    for (int i = 0; i < 3; i++) step(mk(1, ADDR_W'(10 + i), 0, 0, 0, 0, 0), 0);
    step(mk(0, 0, 1, 32'hA, 5'h00, 0, 0), 0);
    step(mk(1, 6'd13, 0, 0, 0, 1, 0), 0);
    chk("simul_ready", issue_ready, 1);
    step(mk(1, 6'd14, 0, 0, 0, 0, 0), 0);
    chk("simul_cnt4", issue_ready, 0);
    for (int i = 0; i < 4; i++) step(mk(0, 0, 1, 32'hB0 + i, 5'h00, 1, 0), 0);
    for (int i = 0; i < 5; i++) step(mk(0, 0, 0, 0, 0, 1, 0), 0);
    chk("simul_idle", busy, 0);

    // Clear collides with a handshake carrying a new flag.
    do_reset();
    step(mk(1, 6'd2, 0, 0, 0, 1, 0), 0);
    step(mk(0, 0, 1, 32'h1, 5'h04, 1, 0), 0);
    step(mk(0, 0, 0, 0, 0, 1, 0), 0);
    chk("ff_first", fflags, 5'h04);
    step(mk(1, 6'd3, 0, 0, 0, 0, 0), 0);
    step(mk(0, 0, 1, 32'h2, 5'h10, 0, 0), 0);
    step(mk(0, 0, 0, 0, 0, 1, 1), 0);
    chk("ff_clr_set", fflags, 5'h10);

    // Orphan result, then reset with work in flight.
    do_reset();
    step(mk(0, 0, 1, 32'h55, 5'h1F, 1, 0), 0);
    chk("orphan_err", err, 1);
    chk("orphan_valid", wb_valid, 0);
    step(mk(0, 0, 0, 0, 0, 1, 0), 0);
    chk("orphan_valid2", wb_valid, 0);
    step(mk(1, 6'd20, 0, 0, 0, 0, 0), 0);
    step(mk(1, 6'd21, 0, 0, 0, 0, 0), 0);
    step(mk(0, 0, 1, 32'hCAFE, 5'h02, 0, 0), 0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
